kbd_scan_decoder: RTL and testbench
===================================

KBD_SCAN_DECODER -- requirements
Module: kbd_scan_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port clrn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port data, input, 8 bits: scan code at the head of the upstream PS/2 FIFO.
REQ-004 SHALL have port ready, input, 1 bit: upstream FIFO is non-empty.
REQ-005 SHALL have port nextdata_n, output, 1 bit: active-low pop strobe to the upstream FIFO.
REQ-006 SHALL have port key_code, output, 8 bits: code byte of the last emitted event.
REQ-007 SHALL have port key_ext, output, 1 bit: last event carried the E0 prefix.
REQ-008 SHALL have port key_release, output, 1 bit: last event was a break (F0) event.
REQ-009 SHALL have port key_valid, output, 1 bit: one-cycle pulse per emitted event.
REQ-010 SHALL have port dir, output, 2 bits: snake direction (0 up, 1 down, 2 left, 3 right).
REQ-011 SHALL have port key_count, output, 8 bits: number of emitted make events.

Function
REQ-012 SHALL run a fetch FSM with states IDLE, POP and WAIT.
REQ-013 SHALL move IDLE->POP on the first edge at which ready=1.
REQ-014 SHALL drive nextdata_n=0 for exactly the POP cycle and 1 in all other states; data SHALL be captured in POP.
REQ-015 SHALL move POP->WAIT->IDLE unconditionally, so at most one byte is consumed per 3 cycles; ready SHALL be ignored in POP and WAIT.
REQ-016 SHALL set a pending-extended flag on byte E0, emitting no event.
REQ-017 SHALL set a pending-break flag on byte F0, emitting no event; repeated F0 keeps the flag set.
REQ-018 SHALL, on byte E1, discard that byte and the next 7 bytes (pause sequence) via a 3-bit skip counter, emitting no event and clearing both flags.
REQ-019 SHALL, on any other byte, in the cycle after capture, load key_code=byte, key_ext=ext flag and key_release=break flag, pulse key_valid for one cycle (subject to REQ-027), then clear both flags.
REQ-020 SHALL, on a make event, update dir: 1D or E0 75 -> 0; 1B or E0 72 -> 1; 1C or E0 6B -> 2; 23 or E0 74 -> 3.
REQ-021 SHALL ignore a direction make that is the exact opposite of the current dir (up/down, left/right), leaving dir unchanged.
REQ-022 SHALL ignore break events for dir.
REQ-023 SHALL increment key_count by 1 on each emitted make event and wrap from 255 to 0.
REQ-024 SHALL hold key_code, key_ext, key_release and dir between events.

Reset
REQ-025 SHALL, while clrn=0, asynchronously force: state IDLE; nextdata_n=1; key_code=00; key_ext=0; key_release=0; key_valid=0; dir=3; key_count=0; both flags and the skip counter 0.
REQ-026 SHALL, when reset is asserted in POP, release nextdata_n within the reset assertion, with no partial event emitted after release.

Configuration
REQ-027 SHALL implement a typematic filter when TYPEMATIC_FILTER_EN is defined: track one held key (code and ext, plus a valid bit); a make matching the held key SHALL produce no key_valid pulse, no key_count increment and no dir change; any other make SHALL replace the held key; a break matching the held key SHALL clear the valid bit. Without the macro, every make SHALL be emitted.

Verification
REQ-028 SHALL show: FIFO supplies 1D -> nextdata_n low for one cycle, key_valid pulse, key_code=1D, key_ext=0, key_release=0, dir=0, key_count=1.
REQ-029 SHALL show: sequence E0 F0 74 -> a single key_valid pulse, key_code=74, key_ext=1, key_release=1, dir unchanged, key_count unchanged.
REQ-030 SHALL show: from reset (dir=3), make 1C -> dir stays 3; then 1D -> dir=0; then 1C -> dir=2.
REQ-031 SHALL show: E1 14 77 E1 F0 14 F0 77, then 23 -> exactly one key_valid pulse, for 23.
REQ-032 SHALL show: 1D 1D 1D F0 1D -> with TYPEMATIC_FILTER_EN, 2 pulses and key_count=1; without it, 4 pulses and key_count=3.
REQ-033 SHALL show: 256 makes of 23 (filter off) -> key_count=0; clrn pulsed low during POP -> nextdata_n=1 immediately and all outputs at their reset values.

Source files
------------

// File: rtl/kbd_scan_decoder.sv
// PS/2 scan-code decoder: pops bytes from an upstream FIFO, folds E0/F0/E1 prefixes
// into key events, tracks a snake direction and a make counter. Optional: TYPEMATIC_FILTER_EN.
module kbd_scan_decoder (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] data,
    input  logic       ready,
    output logic       nextdata_n,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_valid,
    output logic [1:0] dir,
    output logic [7:0] key_count
);

    typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;

    state_t     state_reg, state_next;
    logic [7:0] byte_reg;
    logic       ext_reg, brk_reg;
    logic [2:0] skip_reg;

    logic       is_prefix, is_event, is_make, emit;
    logic       cand_valid, opposite, repeat_make;
    logic [1:0] cand_dir;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // One byte per IDLE->POP->WAIT round trip; ready only matters in IDLE.
    always_comb begin
        state_next = state_reg;
        nextdata_n = 1'b1;
        case (state_reg)
            IDLE:    if (ready) state_next = POP;
            POP: begin
                nextdata_n = 1'b0;
                state_next = WAIT;
            end
            WAIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cand_valid = 1'b1;
        cand_dir   = 2'd0;
        case ({ext_reg, byte_reg})
            9'h01D, 9'h175: cand_dir = 2'd0;
            9'h01B, 9'h172: cand_dir = 2'd1;
            9'h01C, 9'h16B: cand_dir = 2'd2;
            9'h023, 9'h174: cand_dir = 2'd3;
            default:        cand_valid = 1'b0;
        endcase
    end

    // Up/down and left/right differ only in bit 0.
    assign opposite  = (cand_dir == {dir[1], ~dir[0]});
    assign is_prefix = (byte_reg == 8'hE0) || (byte_reg == 8'hF0) || (byte_reg == 8'hE1);
    assign is_event  = (state_reg == WAIT) && (skip_reg == 3'd0) && !is_prefix;
    assign is_make   = !brk_reg;

`ifdef TYPEMATIC_FILTER_EN
    logic [7:0] held_code;
    logic       held_ext, held_valid, held_match;

    assign held_match  = held_valid && (held_code == byte_reg) && (held_ext == ext_reg);
    assign repeat_make = held_match;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            held_code  <= 8'h00;
            held_ext   <= 1'b0;
            held_valid <= 1'b0;
        end else if (is_event) begin
            if (is_make && !held_match) begin
                held_code  <= byte_reg;
                held_ext   <= ext_reg;
                held_valid <= 1'b1;
            end else if (!is_make && held_match) begin
                held_valid <= 1'b0;
            end
        end
    end
`else
    assign repeat_make = 1'b0;
`endif

    assign emit = is_event && !(is_make && repeat_make);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            byte_reg    <= 8'h00;
            ext_reg     <= 1'b0;
            brk_reg     <= 1'b0;
            skip_reg    <= 3'd0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_valid   <= 1'b0;
            dir         <= 2'd3;
            key_count   <= 8'h00;
        end else begin
            key_valid <= emit;
            if (state_reg == POP) byte_reg <= data;

            if (state_reg == WAIT) begin
                if (skip_reg != 3'd0) begin
                    skip_reg <= skip_reg - 3'd1;
                end else if (byte_reg == 8'hE1) begin
                    skip_reg <= 3'd7;
                    ext_reg  <= 1'b0;
                    brk_reg  <= 1'b0;
                end else if (byte_reg == 8'hE0) begin
                    ext_reg <= 1'b1;
                end else if (byte_reg == 8'hF0) begin
                    brk_reg <= 1'b1;
                end else begin
                    ext_reg <= 1'b0;
                    brk_reg <= 1'b0;
                end
            end

            if (emit) begin
                key_code    <= byte_reg;
                key_ext     <= ext_reg;
                key_release <= brk_reg;
                if (is_make) begin
                    key_count <= key_count + 8'd1;
                    if (cand_valid && !opposite) dir <= cand_dir;
                end
            end
        end
    end

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Scoreboard bench for kbd_scan_decoder: a behavioural byte-stream model queues expected
// events, a negedge monitor pops and compares them as key_valid pulses appear.
module tb_kbd_scan_decoder;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready = 1'b0;
    logic       nextdata_n;
    logic [7:0] key_code;
    logic       key_ext, key_release, key_valid;
    logic [1:0] dir;
    logic [7:0] key_count;

    kbd_scan_decoder dut (
        .clk(clk), .clrn(clrn), .data(data), .ready(ready), .nextdata_n(nextdata_n),
        .key_code(key_code), .key_ext(key_ext), .key_release(key_release),
        .key_valid(key_valid), .dir(dir), .key_count(key_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [1:0] d;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         pulse_cnt = 0;
    int         low_run = 0;

    // reference model state
    int         m_skip;
    logic       m_ext, m_brk, m_hv, m_he;
    logic [7:0] m_hc, m_cnt;
    logic [1:0] m_dir;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_skip = 0; m_ext = 1'b0; m_brk = 1'b0; m_hv = 1'b0; m_he = 1'b0;
        m_hc = 8'h00; m_cnt = 8'h00; m_dir = 2'd3;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic       emit;
        logic       has_dir;
        logic [1:0] nd;
        exp_t       e;
        if (m_skip != 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7; m_ext = 1'b0; m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            emit = 1'b1;
            if (!m_brk) begin
`ifdef TYPEMATIC_FILTER_EN
                if (m_hv && m_hc == b && m_he == m_ext) emit = 1'b0;
                else begin m_hv = 1'b1; m_hc = b; m_he = m_ext; end
`endif
                if (emit) begin
                    m_cnt = m_cnt + 8'd1;
                    has_dir = 1'b1;
                    nd = 2'd0;
                    if      ((!m_ext && b == 8'h1D) || (m_ext && b == 8'h75)) nd = 2'd0;
                    else if ((!m_ext && b == 8'h1B) || (m_ext && b == 8'h72)) nd = 2'd1;
                    else if ((!m_ext && b == 8'h1C) || (m_ext && b == 8'h6B)) nd = 2'd2;
                    else if ((!m_ext && b == 8'h23) || (m_ext && b == 8'h74)) nd = 2'd3;
                    else has_dir = 1'b0;
                    // up(0)/down(1) and left(2)/right(3) are mutual opposites
                    if (has_dir && !((m_dir == 2'd0 && nd == 2'd1) || (m_dir == 2'd1 && nd == 2'd0) ||
                                     (m_dir == 2'd2 && nd == 2'd3) || (m_dir == 2'd3 && nd == 2'd2)))
                        m_dir = nd;
                end
            end else begin
`ifdef TYPEMATIC_FILTER_EN
                if (m_hv && m_hc == b && m_he == m_ext) m_hv = 1'b0;
`endif
            end
            if (emit) begin
                e.code = b; e.ext = m_ext; e.rel = m_brk; e.d = m_dir; e.cnt = m_cnt;
                exp_q.push_back(e);
            end
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        fifo.push_back(b);
        model_byte(b);
    endtask

    task automatic drain(input int limit);
        logic done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (fifo.size() == 0) begin done = 1'b1; break; end
        end
        chk("drain", {31'd0, done}, 32'd1);
        repeat (6) @(negedge clk);
        chk("pending_events", exp_q.size(), 0);
        chk("key_count", key_count, m_cnt);
        chk("dir", dir, m_dir);
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        fifo.delete();
        exp_q.delete();
        model_reset();
        pulse_cnt = 0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_nextdata_n", nextdata_n, 1);
        chk("rst_key_code", key_code, 0);
        chk("rst_key_ext", key_ext, 0);
        chk("rst_key_release", key_release, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_dir", dir, 3);
        chk("rst_key_count", key_count, 0);
    endtask

    // Upstream FIFO emulation: pop on a strobe seen at negedge, refresh head after posedge.
    initial begin
        logic pop_pend;
        forever begin
            @(negedge clk);
            pop_pend = clrn && !nextdata_n;
            @(posedge clk);
            #1;
            if (pop_pend && fifo.size() != 0) void'(fifo.pop_front());
            ready = (fifo.size() != 0);
            data  = ready ? fifo[0] : 8'h00;
        end
    end

    // Event monitor and pop-strobe width check.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!nextdata_n) low_run++;
            else if (low_run != 0) begin
                chk("pop_width", low_run, 1);
                low_run = 0;
            end
            if (clrn && key_valid) begin
                pulse_cnt++;
                if (exp_q.size() == 0) chk("spurious_valid", {24'd0, key_code}, 32'hFFFF);
                else begin
                    e = exp_q.pop_front();
                    $display("event code=%02h ext=%0d rel=%0d dir=%0d cnt=%0d", key_code, key_ext,
                             key_release, dir, key_count);
                    chk("ev_code", key_code, e.code);
                    chk("ev_ext", key_ext, e.ext);
                    chk("ev_release", key_release, e.rel);
                    chk("ev_dir", dir, e.d);
                    chk("ev_count", key_count, e.cnt);
                end
            end
        end
    end

    initial begin
        logic [7:0] alphabet [12] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hE0, 8'hF0,
                                      8'h72, 8'h74, 8'h6B, 8'h75, 8'hE1, 8'h14};
        logic seen;
        model_reset();
        #12;
        chk_reset_vals();
        @(negedge clk);
        clrn = 1'b1;

        // single make 1D
        send(8'h1D);
        drain(100);
        chk("req28_count", key_count, 1);
        chk("req28_dir", dir, 0);

        // E0 F0 74: extended break, dir/count unchanged
        send(8'hE0); send(8'hF0); send(8'h74);
        drain(100);
        chk("req29_count", key_count, 1);
        chk("req29_dir", dir, 0);

        // opposite-direction rejection from reset
        do_reset();
        send(8'h1C);
        drain(100);
        chk("req30_dir_a", dir, 3);
        send(8'h1D); send(8'h1C);
        drain(100);
        chk("req30_dir_b", dir, 2);

        // pause sequence swallowed, then 23
        pulse_cnt = 0;
        foreach (alphabet[i]) begin end
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); send(8'h23);
        drain(200);
        chk("req31_pulses", pulse_cnt, 1);
        chk("req31_code", key_code, 8'h23);

        // typematic repeat
        do_reset();
        send(8'h1D); send(8'h1D); send(8'h1D); send(8'hF0); send(8'h1D);
        drain(200);
`ifdef TYPEMATIC_FILTER_EN
        chk("req32_pulses", pulse_cnt, 2);
        chk("req32_count", key_count, 1);
`else
        chk("req32_pulses", pulse_cnt, 4);
        chk("req32_count", key_count, 3);
`endif

        // counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) send(8'h23);
        drain(2000);
`ifndef TYPEMATIC_FILTER_EN
        chk("req33_wrap", key_count, 0);
`endif

        // random mix from a small alphabet
        do_reset();
        for (int i = 0; i < 60; i++) send(alphabet[$urandom_range(0, 11)]);
        drain(600);

        // reset asserted while in POP
        do_reset();
        send(8'h1D);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!nextdata_n) begin seen = 1'b1; break; end
        end
        chk("pop_seen", {31'd0, seen}, 1);
        #2;
        clrn = 1'b0;
        #1;
        chk_reset_vals();
        fifo.delete();
        exp_q.delete();
        model_reset();
        pulse_cnt = 0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_pulses", pulse_cnt, 0);
        chk("post_rst_count", key_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
